// File: rtl/pc_next_unit_if.sv
// Bus between the fetch-stage PC unit and its neighbours: instruction-memory
// handshake, redirect requests from execute/trap logic, and PC status outputs.
//
// Handshake: the PC unit raises fetch_valid while pc is a real fetch request;
// instruction memory raises fetch_ready when it takes pc this cycle. A fetch is
// accepted on a rising edge where fetch_valid && fetch_ready && !stall &&
// !trap_valid all hold. Redirects (trap_valid/br_taken/jmp_valid) are single-cycle
// level requests sampled on that same edge; they carry no ready of their own.
interface pc_next_unit_if #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned CNT_WIDTH = 64
);
  logic                 fetch_ready;
  logic                 stall;
  logic                 inst_is_compressed;
  logic                 br_taken;
  logic [XLEN-1:0]      br_target;
  logic                 jmp_valid;
  logic [XLEN-1:0]      jmp_target;
  logic                 trap_valid;
  logic [XLEN-1:0]      trap_vector;
  logic                 fetch_valid;
  logic [XLEN-1:0]      pc;
  logic [XLEN-1:0]      pc_plus_step;
  logic                 misalign_err;
  logic [XLEN-1:0]      misalign_addr;
  logic [CNT_WIDTH-1:0] fetch_count;

  // Requester side: memory, execute and trap logic.
  modport master (
    output fetch_ready, stall, inst_is_compressed,
    output br_taken, br_target, jmp_valid, jmp_target, trap_valid, trap_vector,
    input  fetch_valid, pc, pc_plus_step, misalign_err, misalign_addr, fetch_count
  );

  // The PC unit itself.
  modport slave (
    input  fetch_ready, stall, inst_is_compressed,
    input  br_taken, br_target, jmp_valid, jmp_target, trap_valid, trap_vector,
    output fetch_valid, pc, pc_plus_step, misalign_err, misalign_addr, fetch_count
  );
endinterface

// File: rtl/pc_next_unit.sv
// Registered program counter with fetch handshake, prioritised redirects
// (trap > branch > jump > sequential), target alignment checking and an
// accepted-fetch counter. State BOOT -> RUN after reset; a misaligned
// branch/jump target parks the unit in FAULT until a trap redirects it.
module pc_next_unit #(
  parameter int unsigned     XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int unsigned     C_EXT        = 0,
  parameter int unsigned     CNT_WIDTH    = 64
) (
  input  logic          clk,
  input  logic          rst,
  pc_next_unit_if.slave bus,
  output logic [1:0]    o_dbg_state
);

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FAULT = 2'd2
  } state_t;

  // Low bits that must be zero in a legal target.
  localparam logic [XLEN-1:0] ALIGN_MASK = (C_EXT != 0) ? XLEN'(1) : XLEN'(3);
  localparam logic [XLEN-1:0] STEP2      = XLEN'(2);
  localparam logic [XLEN-1:0] STEP4      = XLEN'(4);

  state_t               r_state;
  state_t               w_state_next;
  logic [XLEN-1:0]      r_pc;
  logic                 r_misalign_err;
  logic [XLEN-1:0]      r_misalign_addr;
  logic [CNT_WIDTH-1:0] r_fetch_count;

  logic [XLEN-1:0]      w_step;
  logic [XLEN-1:0]      w_pc_plus_step;
  logic [XLEN-1:0]      w_trap_target;
  logic                 w_br_mis;
  logic                 w_jmp_mis;
  logic                 w_accept;
  logic [XLEN-1:0]      w_pc_next;
  logic                 w_fault;
  logic [XLEN-1:0]      w_fault_addr;

  // Step size: compressed instructions advance by 2 only when C is enabled.
  always_comb begin
    w_step = STEP4;
    if ((C_EXT != 0) && bus.inst_is_compressed) w_step = STEP2;
  end

  assign w_pc_plus_step = r_pc + w_step;
  assign w_trap_target  = bus.trap_vector & ~ALIGN_MASK;
  assign w_br_mis       = |(bus.br_target & ALIGN_MASK);
  assign w_jmp_mis      = |(bus.jmp_target & ALIGN_MASK);
  assign w_accept       = (r_state == ST_RUN) && bus.fetch_ready && !bus.stall && !bus.trap_valid;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_BOOT;
    else     r_state <= w_state_next;
  end

  // Next state and next pc; a lower-priority request never rescues a faulting one.
  always_comb begin
    w_state_next = r_state;
    w_pc_next    = r_pc;
    w_fault      = 1'b0;
    w_fault_addr = r_misalign_addr;
    case (r_state)
      ST_BOOT: w_state_next = ST_RUN;
      ST_RUN: begin
        if (bus.trap_valid) begin
          w_pc_next = w_trap_target;
        end else if (bus.br_taken && !bus.stall) begin
          if (w_br_mis) begin
            w_state_next = ST_FAULT;
            w_fault      = 1'b1;
            w_fault_addr = bus.br_target;
          end else begin
            w_pc_next = bus.br_target;
          end
        end else if (bus.jmp_valid && !bus.stall) begin
          if (w_jmp_mis) begin
            w_state_next = ST_FAULT;
            w_fault      = 1'b1;
            w_fault_addr = bus.jmp_target;
          end else begin
            w_pc_next = bus.jmp_target;
          end
        end else if (bus.fetch_ready && !bus.stall) begin
          w_pc_next = w_pc_plus_step;
        end
      end
      ST_FAULT: begin
        if (bus.trap_valid) begin
          w_pc_next    = w_trap_target;
          w_state_next = ST_RUN;
        end
      end
      default: w_state_next = ST_BOOT;
    endcase
  end

  // FSM-derived outputs.
  always_comb begin
    bus.fetch_valid = (r_state == ST_RUN);
    o_dbg_state     = r_state;
  end

  // Datapath registers: pc, fault pulse/address and fetch counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc            <= RESET_VECTOR;
      r_misalign_err  <= 1'b0;
      r_misalign_addr <= '0;
      r_fetch_count   <= '0;
    end else begin
      r_pc            <= w_pc_next;
      r_misalign_err  <= w_fault;
      r_misalign_addr <= w_fault_addr;
      if (w_accept) r_fetch_count <= r_fetch_count + CNT_WIDTH'(1);
    end
  end

  assign bus.pc            = r_pc;
  assign bus.pc_plus_step  = w_pc_plus_step;
  assign bus.misalign_err  = r_misalign_err;
  assign bus.misalign_addr = r_misalign_addr;
  assign bus.fetch_count   = r_fetch_count;

endmodule

// File: tb/tb_pc_next_unit.sv
// Directed bench for pc_next_unit: one instance with C_EXT=0 / RESET_VECTOR=0x100,
// one with C_EXT=1 / RESET_VECTOR=0x10 / CNT_WIDTH=4. Expected values hand-computed.
module tb_pc_next_unit;

  logic       clk;
  logic       rst0;
  logic       rst1;
  logic [1:0] st0;
  logic [1:0] st1;

  int n_checks = 0;
  int n_pass   = 0;

  localparam logic [1:0] S_BOOT  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_FAULT = 2'd2;

  pc_next_unit_if #(.XLEN(32), .CNT_WIDTH(64)) if0 ();
  pc_next_unit_if #(.XLEN(32), .CNT_WIDTH(4))  if1 ();

  pc_next_unit #(.XLEN(32), .RESET_VECTOR(32'h100), .C_EXT(0), .CNT_WIDTH(64)) dut0 (
    .clk(clk), .rst(rst0), .bus(if0), .o_dbg_state(st0)
  );

  pc_next_unit #(.XLEN(32), .RESET_VECTOR(32'h10), .C_EXT(1), .CNT_WIDTH(4)) dut1 (
    .clk(clk), .rst(rst1), .bus(if1), .o_dbg_state(st1)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    else n_pass++;
  endtask

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle0();
    if0.fetch_ready = 0; if0.stall = 0; if0.inst_is_compressed = 0;
    if0.br_taken = 0; if0.br_target = '0; if0.jmp_valid = 0; if0.jmp_target = '0;
    if0.trap_valid = 0; if0.trap_vector = '0;
  endtask

  task automatic idle1();
    if1.fetch_ready = 0; if1.stall = 0; if1.inst_is_compressed = 0;
    if1.br_taken = 0; if1.br_target = '0; if1.jmp_valid = 0; if1.jmp_target = '0;
    if1.trap_valid = 0; if1.trap_vector = '0;
  endtask

  initial begin
    rst0 = 1; rst1 = 1;
    idle0(); idle1();
    repeat (2) tick();

    // ---------------- Instance 0: C_EXT=0 ----------------
    check("rst_pc", if0.pc, 64'h100);
    check("rst_fv", if0.fetch_valid, 0);
    check("rst_err", if0.misalign_err, 0);
    check("rst_addr", if0.misalign_addr, 0);
    check("rst_cnt", if0.fetch_count, 0);
    check("rst_state", st0, S_BOOT);
    check("rst_link", if0.pc_plus_step, 64'h104);

    rst0 = 0;
    if0.fetch_ready = 1;
    #2;
    check("boot_fv", if0.fetch_valid, 0);
    tick();
    check("run_fv", if0.fetch_valid, 1);
    check("run_pc0", if0.pc, 64'h100);
    check("run_cnt0", if0.fetch_count, 0);
    tick(); check("seq_pc1", if0.pc, 64'h104);
    tick(); check("seq_pc2", if0.pc, 64'h108);
    tick(); check("seq_pc3", if0.pc, 64'h10C);
    check("seq_cnt3", if0.fetch_count, 3);

    // Branch held off by stall, then taken.
    if0.stall = 1; if0.br_taken = 1; if0.br_target = 32'h200;
    tick(); check("stall_pc_a", if0.pc, 64'h10C);
    tick(); check("stall_pc_b", if0.pc, 64'h10C);
    check("stall_cnt", if0.fetch_count, 3);
    if0.stall = 0;
    tick(); check("br_pc", if0.pc, 64'h200);
    check("br_cnt", if0.fetch_count, 4);

    // Trap beats stalled branch+jump; low bits cleared.
    if0.br_target = 32'h300; if0.jmp_valid = 1; if0.jmp_target = 32'h400;
    if0.trap_valid = 1; if0.trap_vector = 32'h803; if0.stall = 1;
    tick(); check("trap_pc", if0.pc, 64'h800);
    check("trap_cnt", if0.fetch_count, 4);
    // Branch beats jump.
    if0.trap_valid = 0; if0.stall = 0;
    tick(); check("br_over_jmp", if0.pc, 64'h300);
    check("br_over_cnt", if0.fetch_count, 5);

    // Misaligned jump -> FAULT.
    if0.br_taken = 0; if0.jmp_target = 32'h402;
    tick();
    check("flt_err", if0.misalign_err, 1);
    check("flt_addr", if0.misalign_addr, 64'h402);
    check("flt_fv", if0.fetch_valid, 0);
    check("flt_pc", if0.pc, 64'h300);
    check("flt_state", st0, S_FAULT);
    check("flt_cnt", if0.fetch_count, 6);
    if0.jmp_valid = 0;
    if0.br_taken = 1; if0.br_target = 32'h600;
    tick();
    check("flt_err_pulse", if0.misalign_err, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("flt_hold_pc", if0.pc, 64'h300);
    end
    check("flt_hold_cnt", if0.fetch_count, 6);
    check("flt_hold_fv", if0.fetch_valid, 0);
    if0.br_taken = 0;
    if0.trap_valid = 1; if0.trap_vector = 32'h40;
    tick();
    check("flt_exit_pc", if0.pc, 64'h40);
    check("flt_exit_state", st0, S_RUN);
    check("flt_exit_addr", if0.misalign_addr, 64'h402);

    // Re-enter FAULT at pc=0x500, then async reset mid-cycle.
    if0.trap_vector = 32'h500;
    tick(); check("pre_rst_pc", if0.pc, 64'h500);
    if0.trap_valid = 0; if0.br_taken = 1; if0.br_target = 32'h501;
    tick(); check("pre_rst_state", st0, S_FAULT);
    #2 rst0 = 1;
    #1;
    check("arst_pc", if0.pc, 64'h100);
    check("arst_fv", if0.fetch_valid, 0);
    check("arst_cnt", if0.fetch_count, 0);
    check("arst_state", st0, S_BOOT);
    check("arst_addr", if0.misalign_addr, 0);
    idle0();

    // ---------------- Instance 1: C_EXT=1, CNT_WIDTH=4 ----------------
    tick();
    rst1 = 0;
    if1.fetch_ready = 1;
    tick(); check("c_run_pc", if1.pc, 64'h10);
    if1.inst_is_compressed = 1;
    #1 check("c_link2", if1.pc_plus_step, 64'h12);
    tick(); check("c_pc1", if1.pc, 64'h12);
    if1.inst_is_compressed = 0;
    tick(); check("c_pc2", if1.pc, 64'h16);
    if1.inst_is_compressed = 1;
    tick(); check("c_pc3", if1.pc, 64'h18);
    if1.inst_is_compressed = 0;
    if1.jmp_valid = 1; if1.jmp_target = 32'h402;
    tick();
    check("c_jmp_pc", if1.pc, 64'h402);
    check("c_jmp_err", if1.misalign_err, 0);
    check("c_jmp_state", st1, S_RUN);
    check("c_cnt4", if1.fetch_count, 4);
    if1.jmp_valid = 0;
    if1.trap_valid = 1; if1.trap_vector = 32'hFFFF_FFFD;
    tick(); check("c_trap_pc", if1.pc, 64'hFFFF_FFFC);
    if1.trap_valid = 0;
    tick(); check("c_wrap_pc", if1.pc, 64'h0);
    check("c_cnt5", if1.fetch_count, 5);
    repeat (10) tick();
    check("c_cnt15", if1.fetch_count, 15);
    tick();
    check("c_cnt_wrap", if1.fetch_count, 0);
    check("c_pc_2c", if1.pc, 64'h2C);

    // Misaligned branch with aligned jump still faults.
    if1.br_taken = 1; if1.br_target = 32'h31;
    if1.jmp_valid = 1; if1.jmp_target = 32'h40;
    tick();
    check("c_mis_state", st1, S_FAULT);
    check("c_mis_pc", if1.pc, 64'h2C);
    check("c_mis_addr", if1.misalign_addr, 64'h31);
    check("c_mis_err", if1.misalign_err, 1);
    check("c_mis_cnt", if1.fetch_count, 1);
    idle1();
    if1.trap_valid = 1; if1.trap_vector = 32'h80;
    tick();
    check("c_exit_pc", if1.pc, 64'h80);
    check("c_exit_fv", if1.fetch_valid, 1);
    idle1();

    // Final report
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pc_next_unit.md
Name: pc_next_unit

Overview:
- Parametrised program-counter unit. Replaces the bare combinational PC+4 adder with a registered PC, a fetch handshake, prioritised redirects (trap/branch/jump), target-alignment checking and an accepted-fetch counter.
- Sits at the head of the fetch stage. Drives the instruction-memory address and receives redirect requests from execute and trap logic.

Parameters:
- XLEN, 32, PC and target width in bits.
- RESET_VECTOR, 0, PC value loaded on reset (XLEN bits).
- C_EXT, 0, 0 means 4-byte alignment and step 4 only; 1 means 2-byte alignment and step 2 or 4 per inst_is_compressed.
- CNT_WIDTH, 64, width of fetch_count.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- fetch_ready  in  1  instruction memory accepts the current pc this cycle.
- stall  in  1  pipeline hold; blocks sequential advance and branch/jump.
- inst_is_compressed  in  1  current fetch is a 16-bit instruction; ignored when C_EXT=0.
- br_taken  in  1  branch redirect request.
- br_target  in  XLEN  branch target.
- jmp_valid  in  1  jump redirect request (JAL/JALR).
- jmp_target  in  XLEN  jump target; the JALR LSB is already cleared upstream.
- trap_valid  in  1  trap redirect request.
- trap_vector  in  XLEN  trap handler address.
- fetch_valid  out  1  pc is a valid fetch request.
- pc  out  XLEN  current PC register.
- pc_plus_step  out  XLEN  combinational pc + step (link value), modulo 2^XLEN.
- misalign_err  out  1  one-cycle pulse when a misaligned target is rejected.
- misalign_addr  out  XLEN  last rejected target.
- fetch_count  out  CNT_WIDTH  number of accepted fetches.

Behaviour:
- Reset values:
  - pc = RESET_VECTOR.
  - fetch_valid = 0, misalign_err = 0, misalign_addr = 0, fetch_count = 0.
  - State = BOOT.
  - Reset is asynchronous; assertion mid-operation clears all state immediately, with no pending redirect retained.
- Step:
  - C_EXT=0: step = 4.
  - C_EXT=1: step = 2 if inst_is_compressed, else 4.
  - All PC arithmetic is modulo 2^XLEN; 0xFFFFFFFC + 4 = 0x00000000 with no flag.
- Alignment rule:
  - A target is misaligned if bits[1:0] != 0 (C_EXT=0) or bit[0] != 0 (C_EXT=1).
  - trap_vector is never checked; its low alignment bits are forced to 0 when loaded.
- States:
  - BOOT: fetch_valid = 0. Moves to RUN on the first clock after reset deassertion. pc stays RESET_VECTOR.
  - RUN: fetch_valid = 1. Per-cycle priority, highest first:
    1. trap_valid: pc <= aligned trap_vector. Overrides stall.
    2. br_taken && !stall:
       - aligned target: pc <= br_target.
       - misaligned target: enter FAULT, misalign_err = 1 for the next cycle, misalign_addr <= br_target, pc unchanged.
    3. jmp_valid && !stall: same handling as the branch case, using jmp_target.
    4. fetch_ready && !stall: pc <= pc + step.
    5. Otherwise pc holds.
  - FAULT: fetch_valid = 0. pc and misalign_addr hold. br_taken, jmp_valid and fetch_ready are ignored. Only trap_valid exits: pc <= aligned trap_vector, state goes to RUN.
- Accepted fetch:
  - Defined as state RUN && fetch_ready && !stall && !trap_valid.
  - fetch_count increments by 1 on each accepted fetch and wraps at 2^CNT_WIDTH.
  - A redirect in the same cycle as an accepted fetch still counts the fetch; the redirect overrides only the sequential increment.
- Simultaneous requests:
  - br_taken and jmp_valid together: the branch wins and the jump is dropped.
  - A misaligned branch with an aligned jump still faults; the lower priority never rescues.
- Latency: every redirect is visible on pc exactly one cycle after the request; there is no bubble insertion.

Test Plan:
- Reset release, RESET_VECTOR=0x100, fetch_ready=1 held for 4 cycles:
  - BOOT for 1 cycle with fetch_valid=0.
  - pc then steps 0x100, 0x104, 0x108, 0x10C.
  - fetch_count=3 after the third accepted fetch.
- stall=1 for 2 cycles with br_taken=1, br_target=0x200 asserted during the stall → pc holds, and fetch_count holds.
  - Then stall=0 with br_taken=1, br_target=0x200 → pc=0x200 next cycle.
- br_taken=1, br_target=0x300 and jmp_valid=1, jmp_target=0x400, plus trap_valid=1, trap_vector=0x803, all in one cycle with stall=1 → pc=0x800 (trap wins, low bits cleared).
  - Repeat without trap and stall=0 → pc=0x300.
- jmp_target=0x402 with C_EXT=0:
  - misalign_err pulses 1 cycle, misalign_addr=0x402, fetch_valid=0, pc unchanged.
  - pc ignores fetch_ready for 5 cycles.
  - trap_valid, trap_vector=0x40 → pc=0x40, RUN.
  - Same target with C_EXT=1 → accepted, pc=0x402.
- C_EXT=1, pc=0x10, inst_is_compressed sequence 1,0,1 → pc 0x12, 0x16, 0x18.
  - pc=0xFFFFFFFC, step 4 → pc=0x00000000.
  - fetch_count preset path via CNT_WIDTH=4: 16 accepts wraps the count to 0.
- Assert rst asynchronously mid-cycle while in FAULT with pc=0x500 → pc=RESET_VECTOR, fetch_valid=0 and fetch_count=0 immediately, before the next clock edge.
